exmem_skid_stage: RTL and testbench

EXMEM_SKID_STAGE -- requirements
Module: exmem_skid_stage

---
 rtl/exmem_skid_stage_pkg.sv | 32 +++
 rtl/exmem_skid_stage_if.sv | 33 +++
 rtl/exmem_skid_stage_slot.sv | 33 +++
 rtl/exmem_skid_stage.sv | 151 +++++++++++++++
 tb/tb_exmem_skid_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/exmem_skid_stage_pkg.sv
// Shared core definitions for the EX/MEM boundary: the packet format,
// the write-back source codes and the skid-stage state encoding.
package exmem_skid_stage_pkg;

  localparam int CORE_XLEN      = 32;
  localparam int CORE_REG_AW    = 5;
  localparam int CORE_WB_SEL_W  = 2;
  localparam int CORE_MEM_VAL_W = 3;

  typedef enum logic [CORE_WB_SEL_W-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic [CORE_XLEN-1:0]      alu_out;
    logic [CORE_XLEN-1:0]      rs2;
    logic [CORE_REG_AW-1:0]    rd;
    wb_sel_e                   wb_sel;
    logic                      reg_we;
    logic                      mem_rw;
    logic [CORE_MEM_VAL_W-1:0] mem_val;
  } exmem_pkt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/exmem_skid_stage_if.sv
// EX -> stage -> MEM bundle plus the forwarding tap and occupancy/debug view.
interface exmem_skid_stage_if;
  import exmem_skid_stage_pkg::*;

  // Handshake: a packet moves on a side exactly in a cycle where valid and
  // ready are both high; valid never depends on ready, and in_ready is a
  // function of registered state and en only.
  logic       in_valid;
  logic       in_ready;
  exmem_pkt_t in_pkt;
  logic       out_valid;
  logic       out_ready;
  exmem_pkt_t out_pkt;

  logic                   fwd_valid;
  logic [CORE_REG_AW-1:0] fwd_rd;
  logic [CORE_XLEN-1:0]   fwd_data;
  logic [1:0]             occupancy;
  state_e                 dbg_state;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt,
    input  fwd_valid, fwd_rd, fwd_data, occupancy, dbg_state
  );

  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt,
    output fwd_valid, fwd_rd, fwd_data, occupancy, dbg_state
  );

endinterface

// File: rtl/exmem_skid_stage_slot.sv
// One pipeline entry: a valid bit plus a packet register. Load wins over
// clear; clear drops only the valid bit so the fields keep their last value.
module exmem_slot
  import exmem_skid_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_clear,
  input  exmem_pkt_t i_pkt,
  output logic       o_valid,
  output exmem_pkt_t o_pkt
);

  logic       r_valid;
  exmem_pkt_t r_pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pkt   <= i_pkt;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pkt   = r_pkt;

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with a one-entry skid buffer so in_ready never
// depends combinationally on out_ready; also taps the youngest ALU result.
module exmem_skid_stage
  import exmem_skid_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int WB_SEL_W  = 2,
  parameter int MEM_VAL_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  exmem_skid_stage_if.slave  bus
);

  // The packet layout comes from the core package, so the widths cannot drift.
  if ((XLEN != CORE_XLEN) || (REG_AW != CORE_REG_AW) ||
      (WB_SEL_W != CORE_WB_SEL_W) || (MEM_VAL_W != CORE_MEM_VAL_W)) begin : g_bad_params
    $error("exmem_skid_stage: parameters must match exmem_skid_stage_pkg widths");
  end

  state_e     r_state;
  state_e     w_next_state;
  logic       w_main_valid;
  logic       w_skid_valid;
  exmem_pkt_t w_main_pkt;
  exmem_pkt_t w_skid_pkt;
  exmem_pkt_t w_main_din;
  logic       w_main_load;
  logic       w_main_clear;
  logic       w_skid_load;
  logic       w_skid_clear;
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_accept;
  logic       w_drain;

  assign w_in_ready  = en & ~w_skid_valid;
  assign w_out_valid = en & w_main_valid;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_drain     = w_out_valid & bus.out_ready;

  exmem_slot u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_pkt   (w_main_din),
    .o_valid (w_main_valid),
    .o_pkt   (w_main_pkt)
  );

  exmem_slot u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pkt   (bus.in_pkt),
    .o_valid (w_skid_valid),
    .o_pkt   (w_skid_pkt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else if (en) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_drain)      w_next_state = ST_FULL;
          else if (!w_accept && w_drain) w_next_state = ST_EMPTY;
        end
        ST_FULL:  if (w_drain) w_next_state = ST_ONE;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Slot controls are qualified by en so a disabled stage changes nothing.
  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    w_main_din   = bus.in_pkt;
    if (en && flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (en) begin
      case (r_state)
        ST_EMPTY: w_main_load = w_accept;
        ST_ONE: begin
          if (w_accept && w_drain) w_main_load  = 1'b1;
          else if (w_accept)       w_skid_load  = 1'b1;
          else if (w_drain)        w_main_clear = 1'b1;
        end
        ST_FULL: begin
          if (w_drain) begin
            w_main_load  = 1'b1;
            w_main_din   = w_skid_pkt;
            w_skid_clear = 1'b1;
          end
        end
        default: begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.in_ready       = w_in_ready;
    bus.out_valid      = w_out_valid;
    bus.out_pkt        = w_main_pkt;
    bus.out_pkt.reg_we = w_main_pkt.reg_we & w_out_valid;
    bus.out_pkt.mem_rw = w_main_pkt.mem_rw & w_out_valid;
    bus.dbg_state      = r_state;
    case (r_state)
      ST_ONE:  bus.occupancy = 2'd1;
      ST_FULL: bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

  // The youngest held entry carries the newest value of its rd.
  always_comb begin
    if (w_skid_valid) begin
      bus.fwd_valid = w_skid_pkt.reg_we && (w_skid_pkt.rd != '0) && (w_skid_pkt.wb_sel == WB_ALU);
      bus.fwd_rd    = w_skid_pkt.rd;
      bus.fwd_data  = w_skid_pkt.alu_out;
    end else begin
      bus.fwd_valid = w_main_valid && w_main_pkt.reg_we && (w_main_pkt.rd != '0) &&
                      (w_main_pkt.wb_sel == WB_ALU);
      bus.fwd_rd    = w_main_pkt.rd;
      bus.fwd_data  = w_main_pkt.alu_out;
    end
  end

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Self-checking bench for exmem_skid_stage: directed scenarios then random
// traffic, all compared against a two-deep FIFO reference model.
module tb_exmem_skid_stage;
  import exmem_skid_stage_pkg::*;

  localparam int W = $bits(exmem_pkt_t);

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic flush;

  exmem_skid_stage_if bus ();

  exmem_skid_stage dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: packets held in order, oldest first, plus the content
  // last seen at the head (the visible packet fields hold it when idle).
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_head;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exmem_pkt_t mk_pkt(input logic [4:0] rd, input logic [31:0] alu,
                                        input wb_sel_e wb, input logic we);
    exmem_pkt_t p;
    p.alu_out = alu;
    p.rs2     = alu ^ 32'hA5A5_5A5A;
    p.rd      = rd;
    p.wb_sel  = wb;
    p.reg_we  = we;
    p.mem_rw  = 1'b1;
    p.mem_val = 3'd5;
    return p;
  endfunction

  function automatic exmem_pkt_t rand_pkt();
    exmem_pkt_t p;
    p.alu_out = $urandom;
    p.rs2     = $urandom;
    p.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    p.wb_sel  = wb_sel_e'($urandom_range(0, 2));
    p.reg_we  = 1'($urandom_range(0, 1));
    p.mem_rw  = 1'($urandom_range(0, 1));
    p.mem_val = 3'($urandom_range(0, 7));
    return p;
  endfunction

  // Drive one cycle, check every output against the model, then advance it.
  task automatic cycle(input logic c_rst, input logic c_en, input logic c_flush,
                       input logic c_in_valid, input exmem_pkt_t c_pkt, input logic c_out_ready);
    exmem_pkt_t eo;
    exmem_pkt_t yg;
    logic ir, ov, fv, acc, drn;
    int occ;
    rst           = c_rst;
    en            = c_en;
    flush         = c_flush;
    bus.in_valid  = c_in_valid;
    bus.in_pkt    = c_pkt;
    bus.out_ready = c_out_ready;
    #2;
    occ = exp_q.size();
    ir  = c_en && (occ < 2);
    ov  = c_en && (occ > 0);
    eo  = exmem_pkt_t'(last_head);
    if (!ov) begin
      eo.reg_we = 1'b0;
      eo.mem_rw = 1'b0;
    end
    fv = 1'b0;
    yg = '0;
    if (occ > 0) begin
      yg = exmem_pkt_t'(exp_q[occ-1]);
      fv = yg.reg_we && (yg.rd != 5'd0) && (yg.wb_sel == WB_ALU);
    end
    check_eq("in_ready",  128'(bus.in_ready),  128'(ir));
    check_eq("out_valid", 128'(bus.out_valid), 128'(ov));
    check_eq("occupancy", 128'(bus.occupancy), 128'(occ));
    check_eq("out_pkt",   128'(bus.out_pkt),   128'(eo));
    check_eq("fwd_valid", 128'(bus.fwd_valid), 128'(fv));
    if (fv) begin
      check_eq("fwd_rd",   128'(bus.fwd_rd),   128'(yg.rd));
      check_eq("fwd_data", 128'(bus.fwd_data), 128'(yg.alu_out));
    end
    @(posedge clk);
    if (c_rst) begin
      exp_q.delete();
      last_head = '0;
    end else if (c_en) begin
      acc = c_in_valid && (occ < 2);
      drn = (occ > 0) && c_out_ready;
      if (c_flush) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(W'(c_pkt));
      end
      if (exp_q.size() > 0) last_head = exp_q[0];
    end
    #1;
  endtask

  task automatic idle(input logic c_out_ready);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, rand_pkt(), c_out_ready);
  endtask

  task automatic offer(input exmem_pkt_t p, input logic c_out_ready);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, p, c_out_ready);
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pkt    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    last_head = '0;

    // Post-reset view, then streaming with a free-running consumer.
    idle(1'b1);
    for (int i = 0; i < 4; i++) offer(rand_pkt(), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: A and B fill the stage, C is refused, then drain in order.
    offer(rand_pkt(), 1'b0);
    offer(rand_pkt(), 1'b0);
    offer(rand_pkt(), 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a new packet offered.
    offer(rand_pkt(), 1'b0);
    offer(rand_pkt(), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, rand_pkt(), 1'b0);
    idle(1'b1);

    // Forwarding candidate selection.
    offer(mk_pkt(5'd5, 32'h1234, WB_ALU, 1'b1), 1'b0);
    offer(mk_pkt(5'd7, 32'h55, WB_MEM, 1'b1), 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    offer(mk_pkt(5'd5, 32'h1234, WB_ALU, 1'b1), 1'b0);
    offer(mk_pkt(5'd7, 32'h55, WB_ALU, 1'b1), 1'b0);
    idle(1'b0);
    idle(1'b1);
    offer(mk_pkt(5'd0, 32'h77, WB_ALU, 1'b1), 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Enable low for three cycles mid-stream.
    offer(rand_pkt(), 1'b1);
    offer(rand_pkt(), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, rand_pkt(), 1'b1);
    offer(rand_pkt(), 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset while full and disabled.
    offer(rand_pkt(), 1'b0);
    offer(rand_pkt(), 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, rand_pkt(), 1'b0);
    idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 9) < 7),
            rand_pkt(),
            1'($urandom_range(0, 9) < 6));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
